// File: rtl/btn_shot_charge.sv
// Shot-power charger: holding the debounced shoot button ramps a power meter,
// releasing it either offers the shot over valid/ready or reports a short tap.
module btn_shot_charge #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned PWR_W    = 8,
  parameter int unsigned MIN_PWR  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_db,
  input  logic             shot_ready,
  output logic             charging,
  output logic [PWR_W-1:0] meter,
  output logic             meter_full,
  output logic             shot_valid,
  output logic [PWR_W-1:0] shot_power,
  output logic             tap_pulse
);

  localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PWR_W-1:0] PWR_MAX  = '1;
  localparam logic [PWR_W-1:0] MIN_LVL  = PWR_W'(MIN_PWR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    PEND   = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
  logic [PWR_W-1:0] meter_q,      meter_d;
  logic [PWR_W-1:0] shot_power_q, shot_power_d;
  logic             btn_prev_q,   btn_prev_d;
  logic             charging_q,   charging_d;
  logic             meter_full_q, meter_full_d;
  logic             shot_valid_q, shot_valid_d;
  logic             tap_pulse_q,  tap_pulse_d;

  logic rise;
  logic fall;

  always_comb begin
    rise = btn_db & ~btn_prev_q;
    fall = ~btn_db & btn_prev_q;

    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    meter_d      = meter_q;
    shot_power_d = shot_power_q;
    shot_valid_d = shot_valid_q;
    tap_pulse_d  = 1'b0;
    btn_prev_d   = btn_db;

    unique case (state_q)
      IDLE: begin
        meter_d   = '0;
        div_cnt_d = '0;
        if (rise) begin
          state_d = CHARGE;
        end
      end

      CHARGE: begin
        // A release wins over a coincident tick: the latched power is the
        // meter value shown in the release cycle.
        if (fall) begin
          div_cnt_d = '0;
          if (meter_q >= MIN_LVL) begin
            state_d      = PEND;
            shot_power_d = meter_q;
            shot_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            tap_pulse_d = 1'b1;
            meter_d     = '0;
          end
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (meter_q != PWR_MAX) begin
            meter_d = meter_q + PWR_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      PEND: begin
        if (shot_ready) begin
          state_d      = IDLE;
          shot_valid_d = 1'b0;
          meter_d      = '0;
        end
      end

      default: begin
        state_d      = IDLE;
        div_cnt_d    = '0;
        meter_d      = '0;
        shot_valid_d = 1'b0;
      end
    endcase

    charging_d   = (state_d == CHARGE);
    meter_full_d = (meter_d == PWR_MAX);
  end

  // btn_prev resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      meter_q      <= '0;
      shot_power_q <= '0;
      btn_prev_q   <= 1'b1;
      charging_q   <= 1'b0;
      meter_full_q <= 1'b0;
      shot_valid_q <= 1'b0;
      tap_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      meter_q      <= meter_d;
      shot_power_q <= shot_power_d;
      btn_prev_q   <= btn_prev_d;
      charging_q   <= charging_d;
      meter_full_q <= meter_full_d;
      shot_valid_q <= shot_valid_d;
      tap_pulse_q  <= tap_pulse_d;
    end
  end

  assign charging   = charging_q;
  assign meter      = meter_q;
  assign meter_full = meter_full_q;
  assign shot_valid = shot_valid_q;
  assign shot_power = shot_power_q;
  assign tap_pulse  = tap_pulse_q;

endmodule

// File: tb/tb_btn_shot_charge.sv
// Bench for btn_shot_charge: directed scenarios followed by random button/ready
// activity, all checked against a cycle-count based reference model.
module tb_btn_shot_charge;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned PWR_W    = 4;
  localparam int unsigned MIN_PWR  = 2;
  localparam int unsigned PWR_MAX  = (1 << PWR_W) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_CHARGE = 1;
  localparam int M_PEND   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_db = 1'b0;
  logic             shot_ready = 1'b0;
  logic             charging;
  logic [PWR_W-1:0] meter;
  logic             meter_full;
  logic             shot_valid;
  logic [PWR_W-1:0] shot_power;
  logic             tap_pulse;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: mode, cycles spent charging, latched power, last button.
  int          m_mode  = M_IDLE;
  int unsigned m_k     = 0;
  int unsigned m_power = 0;
  bit          m_prev  = 1'b1;
  bit          m_tap   = 1'b0;

  btn_shot_charge #(
    .TICK_DIV (TICK_DIV),
    .PWR_W    (PWR_W),
    .MIN_PWR  (MIN_PWR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_db     (btn_db),
    .shot_ready (shot_ready),
    .charging   (charging),
    .meter      (meter),
    .meter_full (meter_full),
    .shot_valid (shot_valid),
    .shot_power (shot_power),
    .tap_pulse  (tap_pulse)
  );

  always #5 clk = ~clk;

  // Meter after k charging cycles is the number of completed TICK_DIV periods.
  function automatic int unsigned m_meter();
    int unsigned lvl;
    case (m_mode)
      M_CHARGE: begin
        lvl = m_k / TICK_DIV;
        return (lvl > PWR_MAX) ? PWR_MAX : lvl;
      end
      M_PEND:  return m_power;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit btn, input bit rdy);
    bit rise;
    bit fall;
    int unsigned cur;
    rise  = btn & ~m_prev;
    fall  = ~btn & m_prev;
    m_tap = 1'b0;
    case (m_mode)
      M_IDLE: if (rise) begin
        m_mode = M_CHARGE;
        m_k    = 0;
      end
      M_CHARGE: if (fall) begin
        cur = m_meter();
        if (cur >= MIN_PWR) begin
          m_mode  = M_PEND;
          m_power = cur;
        end else begin
          m_mode = M_IDLE;
          m_tap  = 1'b1;
        end
      end else begin
        m_k++;
      end
      default: if (rdy) m_mode = M_IDLE;
    endcase
    m_prev = btn;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned em;
    em = m_meter();
    chk("charging",   32'(charging),   32'(m_mode == M_CHARGE));
    chk("meter",      32'(meter),      em);
    chk("meter_full", 32'(meter_full), 32'(em == PWR_MAX));
    chk("shot_valid", 32'(shot_valid), 32'(m_mode == M_PEND));
    if (m_mode == M_PEND) chk("shot_power", 32'(shot_power), m_power);
    chk("tap_pulse",  32'(tap_pulse),  32'(m_tap));
  endtask

  // Apply inputs for one cycle, advance the model across the edge, then check.
  task automatic step(input bit btn, input bit rdy);
    btn_db     = btn;
    shot_ready = rdy;
    @(posedge clk);
    model_step(btn, rdy);
    #1;
    check_all();
  endtask

  // Called 1 time unit after a rising edge; outputs must clear before the next edge.
  task automatic async_reset();
    rst_n  = 1'b0;
    #2;
    m_mode = M_IDLE;
    m_k    = 0;
    m_prev = 1'b1;
    m_tap  = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    // Button held through reset, then released and pressed again.
    btn_db = 1'b1;
    async_reset();
    repeat (20) step(1'b1, 1'b0);
    chk("t1_no_charge", 32'(charging), 32'd0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t1_charge", 32'(charging), 32'd1);

    // Keep holding to power 10, then a delayed accept.
    repeat (40) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t2_valid", 32'(shot_valid), 32'd1);
    chk("t2_power", 32'(shot_power), 32'd10);
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("t2_accept", 32'(shot_valid), 32'd0);

    // Long hold saturates the meter.
    step(1'b1, 1'b0);
    repeat (100) step(1'b1, 1'b0);
    chk("t3_meter", 32'(meter), 32'd15);
    chk("t3_full", 32'(meter_full), 32'd1);
    step(1'b0, 1'b0);
    chk("t3_power", 32'(shot_power), 32'd15);
    step(1'b0, 1'b1);

    // Short press gives a tap.
    step(1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    chk("t4_meter", 32'(meter), 32'd1);
    step(1'b0, 1'b0);
    chk("t4_tap", 32'(tap_pulse), 32'd1);
    step(1'b0, 1'b0);
    chk("t4_tap_end", 32'(tap_pulse), 32'd0);
    chk("t4_no_shot", 32'(shot_valid), 32'd0);

    // Release in a tick cycle, then presses during PEND held past accept.
    step(1'b1, 1'b0);
    repeat (11) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t5_power", 32'(shot_power), 32'd2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    chk("t5_no_recharge", 32'(charging), 32'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t5_fresh", 32'(charging), 32'd1);

    // Reset mid-CHARGE and mid-PEND.
    repeat (6) step(1'b1, 1'b0);
    async_reset();
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t6_pend", 32'(shot_valid), 32'd1);
    repeat (2) step(1'b0, 1'b0);
    async_reset();
    repeat (5) step(1'b0, 1'b1);
    chk("t6_dropped", 32'(shot_valid), 32'd0);

    // Random slow-changing button, random ready, rare resets.
    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 11) == 0) b = ~b;
        if ($urandom_range(0, 499) == 0) async_reset();
        else step(b, $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
